if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Fetch stage: PC register, next-PC select and IF/ID pipeline register.
//  Sits directly upstream of the hazard detection unit. Consumes its stall/flush_ID outputs and the ID-stage redirect.
//  Feeds ID with pc, pc+4, the instruction and a valid bit.
//  Contains a boot FSM that holds fetch for a fixed wait after reset.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset
//  BOOT_WAIT     2              cycles in BOOT after reset release before the first fetch (0 = fetch on the first edge)
//  NOP_INSTR     32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous active-low reset
//  stall          in   1   hold PC and IF/ID (load-use)
//  flush_ID       in   1   squash IF/ID contents (bubble)
//  redirect_en    in   1   taken branch/jump resolved in ID
//  redirect_pc    in   32  target PC
//  imem_addr      out  32  instruction memory address (= pc_q, combinational)
//  imem_rdata     in   32  instruction at imem_addr (combinational read)
//  if_id_pc       out  32  PC of the instruction in ID
//  if_id_pc4      out  32  if_id_pc + 4
//  if_id_instr    out  32  instruction in ID (NOP_INSTR when invalid)
//  if_id_valid    out  1   ID holds a real instruction
//  misalign_err   out  1   1-cycle pulse: redirect_pc[1:0] != 0 was accepted
// BEHAVIOUR
//  Reset (async): state=BOOT, boot_cnt=0, pc_q=RESET_VECTOR.
//   IF/ID at reset: pc=0, pc4=0, instr=NOP_INSTR, valid=0. misalign_err=0.
//  FSM BOOT:
//   - pc_q and IF/ID hold; valid=0; boot_cnt increments each cycle.
//   - When boot_cnt==BOOT_WAIT-1 (or immediately if BOOT_WAIT==0), move to RUN.
//   - stall, flush_ID and redirect_en are ignored in BOOT.
//  FSM RUN: per edge, highest priority first:
//   1. stall=1:
//      - pc_q holds; redirect_en is ignored (ID re-resolves next cycle).
//      - IF/ID holds, unless flush_ID=1, which clears valid and sets instr=NOP_INSTR.
//   2. redirect_en=1:
//      - pc_q <= {redirect_pc[31:2],2'b00}.
//      - IF/ID bubble (valid=0, instr=NOP_INSTR), regardless of flush_ID.
//   3. flush_ID=1 without redirect:
//      - pc_q <= pc_q+4.
//      - IF/ID bubble.
//   4. Otherwise (normal fetch):
//      - pc_q <= pc_q+4.
//      - IF/ID <= {pc_q, pc_q+4, imem_rdata, valid=1}.
//  Arithmetic:
//   - All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no error.
//  Latency:
//   - An instruction appears in ID one edge after its PC is on imem_addr.
//   - A redirect target appears in ID two edges after redirect_en is sampled.
//  misalign_err:
//   - Registered.
//   - High for exactly the cycle after a redirect with nonzero low bits is accepted (RUN, stall=0).
//  Reset asserted mid-operation returns to BOOT with the reset values above. Any in-flight redirect is lost.
// CONFIGURATION
//  IF_PERF_CNT_EN defined:
//   - Adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0] and perf_fetch_cnt[31:0].
//   - Counters increment in RUN on, respectively:
//     - stall=1;
//     - a bubble inserted by redirect or flush_ID;
//     - a valid IF/ID load.
//   - Counters saturate at 32'hFFFF_FFFF and reset to 0.
//  Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset release, BOOT_WAIT=2, imem returns addr|1:
//     - if_id_valid stays 0 for 2 edges.
//     - Then if_id_pc = 0, 4, 8 on consecutive edges, with if_id_instr=pc|1.
//  2. RUN with stall=1 for 3 cycles at pc_q=0x10:
//     - imem_addr stays 0x10; IF/ID stays unchanged.
//     - After release, pc advances to 0x14.
//  3. redirect_en=1, redirect_pc=0x100:
//     - Next edge: pc_q=0x100, if_id_valid=0, if_id_instr=0x00000013.
//     - Following edge: if_id_pc=0x100, valid=1.
//  4. stall=1 together with redirect_en=1 (redirect_pc=0x200):
//     - pc_q unchanged; no redirect taken.
//  5. redirect_pc=0x203:
//     - pc_q=0x200; misalign_err high for exactly one cycle.
//  6. pc_q=0xFFFF_FFFC, no events:
//     - Next pc_q=0; the IF_PERF_CNT_EN build shows perf_fetch_cnt incrementing each valid load.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register. A short boot sequence holds fetch after reset.
// Optional build macro IF_PERF_CNT_EN adds saturating stall, bubble and
// fetch counters.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_WAIT    = 2,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush_ID,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_fetch_cnt,
`endif
  output logic        misalign_err
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Last boot counter value before fetching starts; unused when BOOT_WAIT is 0.
  localparam logic [31:0] BOOT_LAST = 32'(BOOT_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] id_pc_d, id_pc4_d, id_instr_d;
  logic        id_valid_d;
  logic        misalign_d;
  logic        run;
  logic        do_stall;
  logic        do_redirect;
  logic        do_flush;
  logic        do_fetch;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;

  // With BOOT_WAIT of 0 the boot state is transparent and the first edge
  // after reset already fetches.
  assign run         = (state_q == RUN) || (BOOT_WAIT == 0);
  assign do_stall    = run && stall;
  assign do_redirect = run && !stall && redirect_en;
  assign do_flush    = run && !stall && !redirect_en && flush_ID;
  assign do_fetch    = run && !stall && !redirect_en && !flush_ID;

  // Boot sequencing state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  // Next boot state, next PC and next IF/ID contents by event priority.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    id_pc_d    = if_id_pc;
    id_pc4_d   = if_id_pc4;
    id_instr_d = if_id_instr;
    id_valid_d = if_id_valid;
    misalign_d = 1'b0;

    if (state_q == BOOT) begin
      boot_cnt_d = boot_cnt_q + 32'd1;
      if ((BOOT_WAIT == 0) || (boot_cnt_q == BOOT_LAST)) begin
        state_d = RUN;
      end
    end

    if (do_stall) begin
      if (flush_ID) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    end else if (do_redirect) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      misalign_d = |redirect_pc[1:0];
    end else if (do_flush) begin
      pc_d       = pc_plus4;
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (do_fetch) begin
      pc_d       = pc_plus4;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_plus4;
      id_instr_d = imem_rdata;
      id_valid_d = 1'b1;
    end
  end

  // PC, IF/ID pipeline register and misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_VECTOR;
      if_id_pc     <= 32'd0;
      if_id_pc4    <= 32'd0;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      if_id_pc     <= id_pc_d;
      if_id_pc4    <= id_pc4_d;
      if_id_instr  <= id_instr_d;
      if_id_valid  <= id_valid_d;
      misalign_err <= misalign_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating event counters; a bubble is counted whenever redirect or
  // flush_ID squashes IF/ID, including a flush during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
      perf_fetch_cnt <= 32'd0;
    end else begin
      if (do_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if ((do_redirect || (run && flush_ID)) && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
      if (do_fetch && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage. Instruction memory returns
// addr|1 so every fetched instruction identifies its own PC.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush_ID;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_err;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] fetch_before;
`endif

  int errors;
  int checks;

  if_stage #(
    .RESET_VECTOR(32'h0000_0000),
    .BOOT_WAIT   (2),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush_ID    (flush_ID),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
`ifdef IF_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_fetch_cnt(perf_fetch_cnt),
`endif
    .misalign_err(misalign_err)
  );

  assign imem_rdata = imem_addr | 32'd1;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic st, input logic fl,
                               input logic re, input logic [31:0] rpc);
    stall       = st;
    flush_ID    = fl;
    redirect_en = re;
    redirect_pc = rpc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a valid IF/ID entry; pc4 and instruction follow from the PC.
  task automatic checkValid(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
    checkOutput({tag, "_pc"}, if_id_pc, pc);
    checkOutput({tag, "_pc4"}, if_id_pc4, pc + 32'd4);
    checkOutput({tag, "_instr"}, if_id_instr, pc | 32'd1);
  endtask

  task automatic checkBubble(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    checkOutput({tag, "_instr"}, if_id_instr, NOP);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    #12;
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_pc", if_id_pc, 32'h0);
    checkOutput("rst_pc4", if_id_pc4, 32'h0);
    checkBubble("rst");
    checkOutput("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // Boot wait: two edges with no fetch, then sequential fetch.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkBubble("boot1");
    checkOutput("boot1_addr", imem_addr, 32'h0);
    step();
    checkBubble("boot2");
    checkOutput("boot2_addr", imem_addr, 32'h0);
    step();
    checkValid("fetch0", 32'h0);
    checkOutput("fetch0_addr", imem_addr, 32'h4);
    step();
    checkValid("fetch4", 32'h4);
    step();
    checkValid("fetch8", 32'h8);
    step();
    checkValid("fetchC", 32'hC);
    checkOutput("pc10_addr", imem_addr, 32'h10);

    // Stall holds PC and IF/ID for three cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_addr", imem_addr, 32'h10);
      checkValid("stall_hold", 32'hC);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    checkOutput("unstall_addr", imem_addr, 32'h14);
    checkValid("unstall", 32'h10);

    // Redirect: bubble first, target in ID one edge later.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
    step();
    checkOutput("redir_addr", imem_addr, 32'h100);
    checkBubble("redir");
    checkOutput("redir_misalign", {31'd0, misalign_err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    checkValid("redir_tgt", 32'h100);
    checkOutput("redir_next_addr", imem_addr, 32'h104);

    // Stall wins over redirect.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
    step();
    checkOutput("stallredir_addr", imem_addr, 32'h104);
    checkValid("stallredir", 32'h100);
    checkOutput("stallredir_misalign", {31'd0, misalign_err}, 32'd0);

    // Misaligned redirect target is aligned and flagged for one cycle.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h203);
    step();
    checkOutput("mis_addr", imem_addr, 32'h200);
    checkOutput("mis_pulse", {31'd0, misalign_err}, 32'd1);
    checkBubble("mis");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    checkOutput("mis_clear", {31'd0, misalign_err}, 32'd0);
    checkValid("mis_tgt", 32'h200);

    // Flush without redirect: PC advances, ID gets a bubble.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    checkOutput("flush_addr", imem_addr, 32'h208);
    checkBubble("flush");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    checkValid("flush_next", 32'h208);

    // Flush during stall: PC held, ID squashed but its PC kept.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    step();
    checkOutput("stallflush_addr", imem_addr, 32'h20C);
    checkBubble("stallflush");
    checkOutput("stallflush_pc", if_id_pc, 32'h208);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    checkValid("stallflush_next", 32'h20C);

    // Redirect together with flush is a single redirect.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    checkOutput("wrap_setup_addr", imem_addr, 32'hFFFF_FFFC);
    checkBubble("redirflush");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
`ifdef IF_PERF_CNT_EN
    fetch_before = perf_fetch_cnt;
`endif
    step();
    checkOutput("wrap_addr", imem_addr, 32'h0);
    checkValid("wrap_top", 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", if_id_pc4, 32'h0);
    step();
    checkValid("wrap_zero", 32'h0);
`ifdef IF_PERF_CNT_EN
    checkOutput("perf_fetch", perf_fetch_cnt, fetch_before + 32'd2);
`endif

    // Reset mid-operation with a redirect pending.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h300);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_addr", imem_addr, 32'h0);
    checkOutput("midrst_pc", if_id_pc, 32'h0);
    checkBubble("midrst");
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    step();
    checkBubble("reboot1");
    step();
    checkBubble("reboot2");
    step();
    checkValid("reboot_fetch", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
